// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
//   XLEN         operand / result width
//   DIV_CYCLES   restoring iterations per operation
//   div_state_e  2-bit FSM encoding (IDLE, CALC, FIX, DONE)
//   div_result_t packed {quo, rem} result payload
package div_unit_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned DIV_CYCLES = 32;
  localparam int unsigned CNT_W      = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  typedef struct packed {
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
  } div_result_t;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? ((~v) + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the divider.
//   start, is_signed, flush, a, b : requester -> divider
//   busy, done, quo, rem          : divider -> requester
interface div_unit_if;
  import div_unit_pkg::*;

  logic            start;
  logic            is_signed;
  logic            flush;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;

  modport master (
    output start, is_signed, flush, a, b,
    input  busy, done, quo, rem
  );

  modport slave (
    input  start, is_signed, flush, a, b,
    output busy, done, quo, rem
  );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : div_unit_if.slave
//            start/is_signed/a/b sampled in IDLE, flush cancels,
//            busy stalls the pipeline in CALC/FIX,
//            done pulses for one cycle in DONE with quo (LO) / rem (HI) valid.
// Timeline: start edge -> 32 CALC cycles -> FIX -> DONE -> IDLE.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  div_unit_if.slave  bus
);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] prem_q;     // {partial remainder, quotient bits}
  logic [XLEN-1:0]   dvsr_q;     // divisor magnitude
  logic              sgn_q;
  logic              a_neg_q;
  logic              b_neg_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   rem_q;

  logic [XLEN:0]     hi_c;
  logic [XLEN:0]     diff_c;
  logic              take_c;
  logic [2*XLEN-1:0] step_c;
  logic [XLEN-1:0]   quo_fix_c;
  logic [XLEN-1:0]   rem_fix_c;
  logic              accept_c;

  // One restoring step: the upper 33 bits of the left-shifted partial
  // remainder are compared with the divisor. Bit 32 of hi_c set means the
  // shifted value already exceeds any 32-bit divisor, so subtract anyway.
  always_comb begin
    hi_c      = prem_q[2*XLEN-1 -: XLEN+1];
    diff_c    = hi_c - {1'b0, dvsr_q};
    take_c    = hi_c[XLEN] | ~diff_c[XLEN];
    step_c    = take_c ? {diff_c[XLEN-1:0], prem_q[XLEN-2:0], 1'b1}
                       : {prem_q[2*XLEN-2:0], 1'b0};
    quo_fix_c = cond_neg(prem_q[XLEN-1:0], sgn_q & (a_neg_q ^ b_neg_q));
    rem_fix_c = cond_neg(prem_q[2*XLEN-1:XLEN], sgn_q & a_neg_q);
  end

  // Next-state logic; flush overrides everything, including a start in IDLE.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.start) state_d = S_CALC;
        S_CALC: if (cnt_q == CNT_W'(DIV_CYCLES - 1)) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign accept_c = (state_q == S_IDLE) && (state_d == S_CALC);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Operand latch and iteration datapath.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      prem_q  <= '0;
      dvsr_q  <= '0;
      sgn_q   <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
    end else if (accept_c) begin
      cnt_q   <= '0;
      prem_q  <= {{XLEN{1'b0}}, cond_neg(bus.a, bus.is_signed & bus.a[XLEN-1])};
      dvsr_q  <= cond_neg(bus.b, bus.is_signed & bus.b[XLEN-1]);
      sgn_q   <= bus.is_signed;
      a_neg_q <= bus.a[XLEN-1];
      b_neg_q <= bus.b[XLEN-1];
    end else if (state_q == S_CALC && state_d == S_CALC) begin
      cnt_q  <= cnt_q + CNT_W'(1);
      prem_q <= step_c;
    end else if (state_q == S_CALC && state_d == S_FIX) begin
      prem_q <= step_c;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= (state_d == S_CALC) || (state_d == S_FIX);
      done_q <= (state_d == S_DONE);
      if (state_q == S_FIX && state_d == S_DONE) begin
        quo_q <= quo_fix_c;
        rem_q <= rem_fix_c;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.quo  = quo_q;
  assign bus.rem  = rem_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver pushes the expected {quo, rem}
// when it issues a start, an independent monitor pops and compares on each
// done pulse. The driver itself checks latency, busy profile, flush and reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  div_unit_if bus();

  div_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;
  div_result_t exp_q[$];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    div_result_t got;
    div_result_t exp;
    if (resetn === 1'b1 && bus.done === 1'b1) begin
      got.quo = bus.quo;
      got.rem = bus.rem;
      if (exp_q.size() == 0) begin
        chk(exp_q.size() != 0, "unexpected_done", got, 64'h0);
      end else begin
        exp = exp_q.pop_front();
        chk(got == exp, "result", got, exp);
      end
    end
  end

  // Issue one operation and follow it to its done pulse. With noise set,
  // extra starts are pulsed during busy and in the DONE cycle.
  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input bit noise);
    div_result_t e;
    int done_cyc;
    bit busy_ok;
    e.quo = eq;
    e.rem = er;
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = sgn; bus.a = a; bus.b = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.a = ~a; bus.b = b ^ 32'h5A5A_0001; bus.is_signed = ~sgn;
    done_cyc = 0;
    busy_ok  = 1'b1;
    for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (noise) begin
        if (cyc == 5 || cyc == 20) begin
          bus.start = 1'b1; bus.a = $urandom; bus.b = $urandom;
        end else begin
          bus.start = 1'b0;
        end
      end
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
      end else if (bus.busy !== (cyc <= 33)) begin
        busy_ok = 1'b0;
      end
    end
    chk(done_cyc == 34, "latency", 64'(done_cyc), 64'd34);
    chk(busy_ok, "busy_profile", 64'(busy_ok), 64'd1);
    if (noise) begin
      bus.start = 1'b1; bus.a = 32'd77; bus.b = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      chk(bus.busy === 1'b0 && bus.done === 1'b0, "start_in_done_ignored",
          {bus.busy, bus.done}, 64'h0);
    end
  endtask

  logic [31:0]        ra, rb, eq, er;
  logic signed [31:0] sa, sb;
  bit                 rs;

  initial begin
    resetn = 1'b0;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.flush = 1'b0;
    bus.a = '0; bus.b = '0;
    #12;
    chk({bus.busy, bus.done, bus.quo, bus.rem} === '0, "reset_state",
        {bus.busy, bus.done, bus.quo[30:0], bus.rem[30:0]}, 64'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed vectors, expected values worked by hand.
    run_op(1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        1'b0);
    run_op(1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0);
    run_op(1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1,        1'b0);
    run_op(1'b0, 32'h12345678,   32'd0,        32'hFFFFFFFF,  32'h12345678, 1'b0);
    run_op(1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0,        1'b0);
    run_op(1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,  32'd0,        1'b0);
    run_op(1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,         32'd0,        1'b0);
    run_op(1'b0, 32'd5,          32'd10,       32'd0,         32'd5,        1'b0);
    run_op(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE, 1'b0);
    run_op(1'b0, 32'h80000000,   32'd3,        32'h2AAAAAAA,  32'd2,        1'b0);
    run_op(1'b1, 32'h80000000,   32'd2,        32'hC0000000,  32'd0,        1'b0);
    run_op(1'b0, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC,  32'd1,        1'b0);
    run_op(1'b1, 32'hFFFFFFFB,   32'd0,        32'd1,         32'hFFFFFFFB, 1'b0);
    // Starts during busy and in DONE must not disturb the first operands.
    run_op(1'b0, 32'd1000,       32'd33,       32'd30,        32'd10,       1'b1);

    // Flush in cycle 10 cancels; outputs keep the previous 1000/33 result.
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd50; bus.b = 32'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk(bus.busy === 1'b0 && bus.done === 1'b0, "flush_idle", {bus.busy, bus.done}, 64'h0);
    chk(bus.quo === 32'd30 && bus.rem === 32'd10, "flush_hold", {bus.quo, bus.rem}, {32'd30, 32'd10});
    repeat (40) @(negedge clk);
    run_op(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

    // Flush together with start in IDLE: nothing starts.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.a = 32'd8; bus.b = 32'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk(bus.busy === 1'b0, "flush_beats_start", 64'(bus.busy), 64'h0);
    repeat (40) @(negedge clk);

    // Reset in cycle 20 of an operation clears outputs at once, no done later.
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd5000; bus.b = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk({bus.busy, bus.done, bus.quo, bus.rem} === '0, "async_reset",
        {bus.busy, bus.done, bus.quo[30:0], bus.rem[30:0]}, 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    chk(bus.quo === 32'd0 && bus.rem === 32'd0, "reset_no_result", {bus.quo, bus.rem}, 64'h0);

    // Back-to-back random pairs against the language's truncating division.
    for (int i = 0; i < 200; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = rb >> $urandom_range(8, 31);
      if (rb == 32'd0) rb = 32'd1;
      if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
      if (rs) begin
        sa = ra; sb = rb;
        eq = sa / sb;
        er = sa % sb;
      end else begin
        eq = ra / rb;
        er = ra % rb;
      end
      run_op(rs, ra, rb, eq, er, 1'b0);
    end

    repeat (4) @(negedge clk);
    chk(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
